// File: rtl/band_peak_tracker_if.sv
// ---------------------------------------------------------------------------
// band_peak_tracker_if
// Streaming bin input and result output of the band peak tracker, grouped.
//   valid_in / ready_in / last_in / bin_in : one signed FFT magnitude bin per
//                                            transfer (valid_in & ready_in)
//   valid_out / ready_out                  : result frame handshake
//   amplitudes_out, freqs_out, peak_mask   : per-band peak, index, mask
//   counter_out, frame_error               : frame number, bin-count error
// Modports: slave = the tracker, master = bin producer / result consumer.
// ---------------------------------------------------------------------------
interface band_peak_tracker_if #(
   parameter int AMPL_WIDTH = 32,
   parameter int FREQ_WIDTH = 4,
   parameter int NBANDS     = 6,
   parameter int TIME_WIDTH = 32
);
   logic                                valid_in;
   logic                                ready_in;
   logic                                last_in;
   logic signed [AMPL_WIDTH-1:0]        bin_in;
   logic                                valid_out;
   logic                                ready_out;
   logic [NBANDS-1:0][AMPL_WIDTH-1:0]   amplitudes_out;
   logic [NBANDS-1:0][FREQ_WIDTH-1:0]   freqs_out;
   logic [NBANDS-1:0]                   peak_mask;
   logic [TIME_WIDTH-1:0]               counter_out;
   logic                                frame_error;

   modport slave (
      input  valid_in, last_in, bin_in, ready_out,
      output ready_in, valid_out, amplitudes_out, freqs_out, peak_mask,
             counter_out, frame_error
   );

   modport master (
      output valid_in, last_in, bin_in, ready_out,
      input  ready_in, valid_out, amplitudes_out, freqs_out, peak_mask,
             counter_out, frame_error
   );
endinterface

// File: rtl/band_peak_tracker.sv
// ---------------------------------------------------------------------------
// band_peak_tracker
// Accepts one signed FFT bin per transfer (bin 0 first). For each of NBANDS
// bands [edge b, edge b+1) it keeps the largest |bin| and its index. On the
// last bin of a frame the peaks (masked to 0 unless > THRESH), the frame
// number and a bin-count error flag are published on a held valid/ready
// result port. If the previous result is still pending, input stalls until
// the consumer takes it.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : band_peak_tracker_if.slave (bin stream in, result frame out)
// ---------------------------------------------------------------------------
module band_peak_tracker #(
   parameter int                           FREQS      = 16,
   parameter int                           FREQ_WIDTH = 4,
   parameter int                           NBANDS     = 6,
   parameter int                           AMPL_WIDTH = 32,
   parameter int                           TIME_WIDTH = 32,
   parameter logic [AMPL_WIDTH-1:0]        THRESH     = '0,
   parameter logic [(NBANDS+1)*16-1:0]     BAND_EDGES =
      {16'd16, 16'd15, 16'd12, 16'd8, 16'd5, 16'd3, 16'd1}
) (
   input logic                clk,
   input logic                reset,
   band_peak_tracker_if.slave bus
);

   typedef enum logic {ACCUM, STALL} state_t;

   // One extra bit so the counter can sit at FREQS and the count including
   // the last bin can exceed it.
   localparam int                    CNT_WIDTH = FREQ_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0]  FREQS_C   = CNT_WIDTH'(FREQS);
   localparam logic [AMPL_WIDTH-1:0] MAG_MAX   = {1'b0, {(AMPL_WIDTH-1){1'b1}}};
   localparam logic [AMPL_WIDTH-1:0] MOST_NEG  = {1'b1, {(AMPL_WIDTH-1){1'b0}}};

   state_t                            state_q, state_d;
   logic [CNT_WIDTH-1:0]              bin_cnt_q, bin_cnt_d;
   logic [NBANDS-1:0][AMPL_WIDTH-1:0] acc_ampl_q, acc_ampl_d, acc_ampl_f;
   logic [NBANDS-1:0][FREQ_WIDTH-1:0] acc_freq_q, acc_freq_d, acc_freq_f;
   logic                              err_pend_q, err_pend_d;
   logic [TIME_WIDTH-1:0]             frame_cnt_q, frame_cnt_d;
   logic                              valid_out_q, valid_out_d;
   logic [NBANDS-1:0][AMPL_WIDTH-1:0] ampl_out_q, ampl_out_d;
   logic [NBANDS-1:0][FREQ_WIDTH-1:0] freq_out_q, freq_out_d;
   logic [NBANDS-1:0]                 mask_q, mask_d;
   logic [TIME_WIDTH-1:0]             counter_q, counter_d;
   logic                              frame_error_q, frame_error_d;

   logic [AMPL_WIDTH-1:0]             mag;
   logic [CNT_WIDTH-1:0]              bin_total;
   logic                              xfer;
   logic                              out_free;
   logic                              load;
   logic                              load_err;

   assign xfer      = bus.valid_in && (state_q == ACCUM);
   assign out_free  = !valid_out_q || bus.ready_out;
   assign bin_total = bin_cnt_q + CNT_WIDTH'(1);

   // |bin_in|; the most negative value has no positive twin, so it saturates.
   always_comb begin
      if ($unsigned(bus.bin_in) == MOST_NEG) begin
         mag = MAG_MAX;
      end else if (bus.bin_in[AMPL_WIDTH-1]) begin
         mag = $unsigned(-bus.bin_in);
      end else begin
         mag = $unsigned(bus.bin_in);
      end
   end

   // Accumulators with the current bin folded in. Strict > keeps the lowest
   // index on ties; bins at or past FREQS, or outside every band, are ignored.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      acc_ampl_f = acc_ampl_q;
      acc_freq_f = acc_freq_q;
      if (xfer && (bin_cnt_q < FREQS_C)) begin
         for (int b = 0; b < NBANDS; b++) begin
            if ((int'(bin_cnt_q) >= int'(BAND_EDGES[b*16 +: 16])) &&
                (int'(bin_cnt_q) <  int'(BAND_EDGES[(b+1)*16 +: 16])) &&
                (mag > acc_ampl_q[b])) begin
               acc_ampl_f[b] = mag;
               acc_freq_f[b] = bin_cnt_q[FREQ_WIDTH-1:0];
            end
         end
      end
   end

   // Next state and output-register load.
   always_comb begin
      state_d       = state_q;
      bin_cnt_d     = bin_cnt_q;
      acc_ampl_d    = acc_ampl_f;
      acc_freq_d    = acc_freq_f;
      err_pend_d    = err_pend_q;
      frame_cnt_d   = frame_cnt_q;
      valid_out_d   = valid_out_q && !bus.ready_out;
      ampl_out_d    = ampl_out_q;
      freq_out_d    = freq_out_q;
      mask_d        = mask_q;
      counter_d     = counter_q;
      frame_error_d = frame_error_q;
      load          = 1'b0;
      load_err      = 1'b0;

      unique case (state_q)
         ACCUM: begin
            if (xfer) begin
               if (bus.last_in) begin
                  bin_cnt_d = '0;
                  if (out_free) begin
                     load     = 1'b1;
                     load_err = (bin_total != FREQS_C);
                  end else begin
                     // Finished frame waits in the accumulators.
                     state_d    = STALL;
                     err_pend_d = (bin_total != FREQS_C);
                  end
               end else if (bin_cnt_q != FREQS_C) begin
                  bin_cnt_d = bin_total;
               end
            end
         end
         STALL: begin
            if (bus.ready_out) begin
               load     = 1'b1;
               load_err = err_pend_q;
               state_d  = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase

      if (load) begin
         acc_ampl_d    = '0;
         acc_freq_d    = '0;
         valid_out_d   = 1'b1;
         counter_d     = frame_cnt_q;
         frame_cnt_d   = frame_cnt_q + TIME_WIDTH'(1);
         frame_error_d = load_err;
         for (int b = 0; b < NBANDS; b++) begin
            mask_d[b]     = (acc_ampl_f[b] > THRESH);
            ampl_out_d[b] = mask_d[b] ? acc_ampl_f[b] : '0;
            freq_out_d[b] = mask_d[b] ? acc_freq_f[b] : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ACCUM;
         bin_cnt_q     <= '0;
         // NOTE: the per-band accumulator arrays are reset too; a partial
         // frame must not leak into the first frame after reset.
         acc_ampl_q    <= '0;
         acc_freq_q    <= '0;
         err_pend_q    <= 1'b0;
         frame_cnt_q   <= '0;
         valid_out_q   <= 1'b0;
         ampl_out_q    <= '0;
         freq_out_q    <= '0;
         mask_q        <= '0;
         counter_q     <= '0;
         frame_error_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every flop samples the values
         // from before this edge regardless of statement order.
         state_q       <= state_d;
         bin_cnt_q     <= bin_cnt_d;
         acc_ampl_q    <= acc_ampl_d;
         acc_freq_q    <= acc_freq_d;
         err_pend_q    <= err_pend_d;
         frame_cnt_q   <= frame_cnt_d;
         valid_out_q   <= valid_out_d;
         ampl_out_q    <= ampl_out_d;
         freq_out_q    <= freq_out_d;
         mask_q        <= mask_d;
         counter_q     <= counter_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign bus.ready_in       = (state_q == ACCUM);
   assign bus.valid_out      = valid_out_q;
   assign bus.amplitudes_out = ampl_out_q;
   assign bus.freqs_out      = freq_out_q;
   assign bus.peak_mask      = mask_q;
   assign bus.counter_out    = counter_q;
   assign bus.frame_error    = frame_error_q;

endmodule

// File: tb/tb_band_peak_tracker.sv
// ---------------------------------------------------------------------------
// tb_band_peak_tracker
// Two trackers (THRESH 0 and THRESH 4) receive identical bin streams. At each
// accepted last bin a reference model computes the expected result for both
// thresholds and pushes it to per-DUT queues; a monitor pops and compares at
// every result handshake. Directed frames cover reset, the worked example,
// ties, saturation, backpressure and bad frame lengths; random frames follow.
// ---------------------------------------------------------------------------
module tb_band_peak_tracker;

   localparam int AW = 32;
   localparam int FW = 4;
   localparam int NB = 6;
   localparam int TW = 32;

   typedef struct packed {
      logic [NB-1:0][AW-1:0] ampl;
      logic [NB-1:0][FW-1:0] freq;
      logic [NB-1:0]         mask;
      logic [TW-1:0]         cnt;
      logic                  ferr;
   } result_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   band_peak_tracker_if #(.AMPL_WIDTH(AW), .FREQ_WIDTH(FW), .NBANDS(NB), .TIME_WIDTH(TW)) bus_a ();
   band_peak_tracker_if #(.AMPL_WIDTH(AW), .FREQ_WIDTH(FW), .NBANDS(NB), .TIME_WIDTH(TW)) bus_b ();

   band_peak_tracker #(.THRESH(32'd0)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   band_peak_tracker #(.THRESH(32'd4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   int      n_cmp = 0;
   int      n_fail = 0;
   result_t q_a[$];
   result_t q_b[$];
   int      frame_bins[$];
   int      model_cnt = 0;
   int      rdy_mode = 2;      // 0 random, 1 held low, 2 held high
   logic    lat_pending = 1'b0;
   logic    lat_free = 1'b0;
   int      edges[7] = '{1, 3, 5, 8, 12, 15, 16};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic print_summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
   endtask

   // Reference: per band, largest saturated |bin| over the accepted bins whose
   // index lies in [lo, hi); first occurrence wins; masked unless > thresh.
   function automatic result_t model(input longint thresh, input int cnt);
      result_t r;
      r = '0;
      for (int b = 0; b < NB; b++) begin
         longint best;
         int     bi;
         best = 0;
         bi   = 0;
         for (int i = edges[b]; i < edges[b+1]; i++) begin
            if (i < frame_bins.size()) begin
               longint m;
               m = longint'(frame_bins[i]);
               if (m < 0) m = -m;
               if (m > 64'd2147483647) m = 64'd2147483647;
               if (m > best) begin
                  best = m;
                  bi   = i;
               end
            end
         end
         if (best > thresh) begin
            r.ampl[b] = best[31:0];
            r.freq[b] = bi[3:0];
            r.mask[b] = 1'b1;
         end
      end
      r.cnt  = cnt;
      r.ferr = (frame_bins.size() != 16);
      return r;
   endfunction

   function automatic int rand_bin();
      int v;
      case ($urandom_range(0, 5))
         0:       v = 0;
         1:       v = int'($urandom_range(0, 20)) - 10;
         2:       v = int'($urandom);
         3:       v = int'(32'h8000_0000);
         4:       v = -int'($urandom_range(1, 100));
         default: v = int'($urandom_range(0, 8));
      endcase
      return v;
   endfunction

   task automatic drive(input logic v, input logic l, input int d);
      bus_a.valid_in = v;  bus_a.last_in = l;  bus_a.bin_in = d;
      bus_b.valid_in = v;  bus_b.last_in = l;  bus_b.bin_in = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b1 & $urandom_range(0, 1), int'($urandom));
      @(posedge clk); #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send_bin(input int v, input logic last);
      logic rdy;
      logic free;
      int   waited;
      waited = 0;
      drive(1'b1, last, v);
      forever begin
         @(negedge clk);
         rdy  = bus_a.ready_in;
         free = !bus_a.valid_out || bus_a.ready_out;
         @(posedge clk); #1;
         if (rdy) break;
         waited++;
         if (waited > 500) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_in_timeout: ready_in stayed 0 for %0d cycles, expected 1", waited);
            print_summary();
            $fatal(1, "bench aborted");
         end
      end
      drive(1'b0, 1'b0, 0);
      frame_bins.push_back(v);
      if (last) begin
         q_a.push_back(model(0, model_cnt));
         q_b.push_back(model(4, model_cnt));
         model_cnt++;
         frame_bins.delete();
         lat_free    = free;
         lat_pending = 1'b1;
      end
   endtask

   task automatic send_frame(input int s[$], input bit gaps);
      for (int i = 0; i < s.size(); i++) begin
         if (gaps && $urandom_range(0, 4) == 0)
            repeat ($urandom_range(1, 3)) idle();
         send_bin(s[i], i == s.size() - 1);
      end
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      rdy_mode = 2;
      while ((q_a.size() != 0 || q_b.size() != 0) && waited < 200) begin
         @(posedge clk);
         waited++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("drain_pending_a", q_a.size(), 0);
      check("drain_pending_b", q_b.size(), 0);
   endtask

   // Consumer ready: changes 3 time units after the edge.
   initial begin
      bus_a.ready_out = 1'b0;
      bus_b.ready_out = 1'b0;
      forever begin
         logic r;
         @(posedge clk); #3;
         case (rdy_mode)
            0:       r = ($urandom_range(0, 9) < 7);
            1:       r = 1'b0;
            default: r = 1'b1;
         endcase
         bus_a.ready_out = r;
         bus_b.ready_out = r;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      result_t act;
      result_t exp;
      if (!reset) begin
         if (bus_a.valid_out && bus_a.ready_out) begin
            act = {bus_a.amplitudes_out, bus_a.freqs_out, bus_a.peak_mask,
                   bus_a.counter_out, bus_a.frame_error};
            if (q_a.size() == 0) begin
               check("a_unexpected_result_counter", act.cnt, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp = q_a.pop_front();
               for (int b = 0; b < NB; b++) begin
                  check($sformatf("a_ampl%0d_frame%0d", b, exp.cnt), act.ampl[b], exp.ampl[b]);
                  check($sformatf("a_freq%0d_frame%0d", b, exp.cnt), act.freq[b], exp.freq[b]);
               end
               check($sformatf("a_mask_frame%0d", exp.cnt), act.mask, exp.mask);
               check("a_counter_out", act.cnt, exp.cnt);
               check($sformatf("a_frame_error_frame%0d", exp.cnt), act.ferr, exp.ferr);
            end
         end
         if (bus_b.valid_out && bus_b.ready_out) begin
            act = {bus_b.amplitudes_out, bus_b.freqs_out, bus_b.peak_mask,
                   bus_b.counter_out, bus_b.frame_error};
            if (q_b.size() == 0) begin
               check("b_unexpected_result_counter", act.cnt, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp = q_b.pop_front();
               for (int b = 0; b < NB; b++) begin
                  check($sformatf("b_ampl%0d_frame%0d", b, exp.cnt), act.ampl[b], exp.ampl[b]);
                  check($sformatf("b_freq%0d_frame%0d", b, exp.cnt), act.freq[b], exp.freq[b]);
               end
               check($sformatf("b_mask_frame%0d", exp.cnt), act.mask, exp.mask);
               check("b_counter_out", act.cnt, exp.cnt);
               check($sformatf("b_frame_error_frame%0d", exp.cnt), act.ferr, exp.ferr);
            end
         end
      end
   end

   // One cycle after a last-bin transfer: result visible if the output was
   // free, otherwise the input side must be stalled.
   always @(negedge clk) begin
      if (lat_pending) begin
         lat_pending = 1'b0;
         if (lat_free) begin
            check("latency_valid_out", bus_a.valid_out, 1);
            check("latency_ready_in", bus_a.ready_in, 1);
         end else begin
            check("stall_ready_in_a", bus_a.ready_in, 0);
            check("stall_ready_in_b", bus_b.ready_in, 0);
         end
      end
   end

   initial begin
      int stim[$];
      int cnt_a;
      int cnt_b;
      int len;

      drive(1'b0, 1'b0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready_in", bus_a.ready_in, 1);
      check("rst_valid_out", bus_a.valid_out, 0);
      check("rst_ampl", bus_a.amplitudes_out[0], 0);
      check("rst_freqs", bus_a.freqs_out, 0);
      check("rst_mask", bus_a.peak_mask, 0);
      check("rst_counter", bus_a.counter_out, 0);
      check("rst_frame_error", bus_a.frame_error, 0);
      check("rst_valid_out_b", bus_b.valid_out, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // T1: reset three bins into a frame, then an all-zero frame.
      rdy_mode = 2;
      for (int i = 0; i < 3; i++) send_bin(1000 + i, 1'b0);
      reset = 1'b1;
      frame_bins.delete();
      q_a.delete();
      q_b.delete();
      model_cnt = 0;
      @(posedge clk);
      @(negedge clk);
      check("t1_rst_ready_in", bus_a.ready_in, 1);
      check("t1_rst_valid_out", bus_a.valid_out, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      stim = '{};
      for (int i = 0; i < 16; i++) stim.push_back(0);
      send_frame(stim, 1'b0);

      // T2 / T4: worked example, checked at both thresholds.
      stim = '{0, 1, 2, 3, 4, 5, 4, 7, 0, -8, 0, 0, 0, 0, 1, 0};
      send_frame(stim, 1'b0);

      // T3: tie in band 1, most negative value in band 3.
      stim = '{0, 1, 0, 5, 5, 2, 3, 1, 0, 0, int'(32'h8000_0000), 7, 0, 2, 0, 9};
      send_frame(stim, 1'b0);

      // T6: short frame, long frame with large dropped bins, normal frame.
      rdy_mode = 0;
      stim = '{};
      for (int i = 0; i < 12; i++) stim.push_back(rand_bin());
      send_frame(stim, 1'b1);
      stim = '{};
      for (int i = 0; i < 16; i++) stim.push_back(int'($urandom_range(0, 50)));
      for (int i = 0; i < 4; i++) stim.push_back(int'(32'h7000_0000) + i);
      send_frame(stim, 1'b1);
      stim = '{};
      for (int i = 0; i < 16; i++) stim.push_back(rand_bin());
      send_frame(stim, 1'b1);

      // T5: consumer blocked across two frames, then a single ready pulse.
      drain();
      rdy_mode = 1;
      cnt_a = model_cnt;
      cnt_b = model_cnt + 1;
      for (int f = 0; f < 2; f++) begin
         stim = '{};
         for (int i = 0; i < 16; i++) stim.push_back(rand_bin());
         send_frame(stim, 1'b0);
      end
      stim = '{};
      for (int i = 0; i < 16; i++) stim.push_back(rand_bin());
      fork
         send_frame(stim, 1'b0);
         begin
            repeat (4) @(negedge clk);
            check("t5_stall_ready_in", bus_a.ready_in, 0);
            check("t5_held_valid_out", bus_a.valid_out, 1);
            check("t5_held_counter", bus_a.counter_out, cnt_a);
            rdy_mode = 2;
            @(posedge clk);
            @(posedge clk);
            rdy_mode = 1;
            @(negedge clk);
            check("t5_resume_ready_in", bus_a.ready_in, 1);
            check("t5_reload_valid_out", bus_a.valid_out, 1);
            check("t5_reload_counter", bus_a.counter_out, cnt_b);
            rdy_mode = 0;
         end
      join

      // Random frames with idle gaps and random backpressure.
      rdy_mode = 0;
      for (int f = 0; f < 40; f++) begin
         len = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(1, 22));
         stim = '{};
         for (int i = 0; i < len; i++) stim.push_back(rand_bin());
         send_frame(stim, 1'b1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) idle();
      end

      drain();
      print_summary();
      $finish;
   end

endmodule
